// File: rtl/serial_nibble_add_ctrl.sv
// Serial nibble adder controller: feeds an external 4-bit adder
// one nibble per cycle and assembles a WIDTH-bit sum and carry-out.
module serial_nibble_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic [3:0]       add_a_o,
  output logic [3:0]       add_b_o,
  output logic             add_cin_o,
  input  logic [3:0]       add_s_i,
  input  logic             add_cout_i
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state_q;
  logic [KW-1:0]         k_q;
  logic                  carry_q;
  logic [NIB-1:0][3:0]   a_q;
  logic [NIB-1:0][3:0]   b_q;
  logic [NIB-1:0][3:0]   sum_q;
  logic                  cout_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  last_nib;

  assign last_nib = (k_q == KW'(NIB - 1));

  // Control FSM with registered status and result outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= cin_i;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[k_q] <= add_s_i;
          carry_q    <= add_cout_i;
          k_q        <= k_q + KW'(1);
          if (last_nib) begin
            cout_q  <= add_cout_i;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Adder operands come straight from registers, zero outside RUN
  always_comb begin
    add_a_o   = 4'h0;
    add_b_o   = 4'h0;
    add_cin_o = 1'b0;
    if (state_q == RUN) begin
      add_a_o   = a_q[k_q];
      add_b_o   = b_q[k_q];
      add_cin_o = carry_q;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_nibble_add_ctrl.sv
// Bench for serial_nibble_add_ctrl: vector table, corner
// sequences and random regression against a scoreboard.
module tb_serial_nibble_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] a_i, b_i;
  logic        cin_i;
  logic        busy_o, done_o, cout_o;
  logic [15:0] sum_o;
  logic [3:0]  add_a_o, add_b_o, add_s_i;
  logic        add_cin_o, add_cout_i;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [16:0] sb[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
  } vec_t;
  vec_t vecs[8];

  serial_nibble_add_ctrl #(.WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .a_i(a_i), .b_i(b_i), .cin_i(cin_i),
    .busy_o(busy_o), .done_o(done_o),
    .sum_o(sum_o), .cout_o(cout_o),
    .add_a_o(add_a_o), .add_b_o(add_b_o),
    .add_cin_o(add_cin_o),
    .add_s_i(add_s_i), .add_cout_i(add_cout_i)
  );

  always #5 clk = ~clk;

  // External 4-bit adder model
  always_comb begin
    {add_cout_i, add_s_i} =
      {1'b0, add_a_o} + {1'b0, add_b_o} + {4'h0, add_cin_o};
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every done_o pulse pops one expected result
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got %0h expected none",
                 {cout_o, sum_o});
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        if ({cout_o, sum_o} !== e) begin
          errors++;
          $display("FAIL result: got %0h expected %0h",
                   {cout_o, sum_o}, e);
        end
      end
    end
  end

  // Called just after a negedge; ends just after the first IDLE negedge
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [16:0] exp);
    logic       cy;
    logic [3:0] na, nb;
    start_i = 1'b1;
    a_i = a;
    b_i = b;
    cin_i = c;
    sb.push_back(exp);
    cy = c;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start_i = 1'b0;
        a_i = 16'($urandom);
        b_i = 16'($urandom);
        cin_i = 1'($urandom);
      end
      if (i <= 4) begin
        na = 4'(a >> (4 * (i - 1)));
        nb = 4'(b >> (4 * (i - 1)));
        chk("run_done", 32'(done_o), 32'd0);
        chk("run_busy", 32'(busy_o), 32'd1);
        chk("add_a", 32'(add_a_o), 32'(na));
        chk("add_b", 32'(add_b_o), 32'(nb));
        chk("add_cin", 32'(add_cin_o), 32'(cy));
        cy = (5'(na) + 5'(nb) + 5'(cy)) >= 5'd16;
      end else if (i == 5) begin
        chk("done_pulse", 32'(done_o), 32'd1);
        chk("done_busy", 32'(busy_o), 32'd1);
        chk("done_add_a", 32'(add_a_o), 32'd0);
      end else begin
        chk("idle_done", 32'(done_o), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_add_a", 32'(add_a_o), 32'd0);
        chk("idle_add_cin", 32'(add_cin_o), 32'd0);
        chk("held_sum", 32'({cout_o, sum_o}), 32'(exp));
      end
    end
  endtask

  initial begin
    int d0;
    int pos[$];
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

    rst_i = 1'b1;
    start_i = 1'b1;
    a_i = 16'h1111;
    b_i = 16'h2222;
    cin_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_sum", 32'(sum_o), 32'd0);
    chk("rst_cout", 32'(cout_o), 32'd0);
    chk("rst_add_a", 32'(add_a_o), 32'd0);
    chk("rst_add_b", 32'(add_b_o), 32'd0);
    rst_i = 1'b0;

    // First start right after reset release, then back-to-back table
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin,
             {vecs[i].co, vecs[i].s});

    // Start pulsed during RUN is ignored
    d0 = done_cnt;
    start_i = 1'b1;
    a_i = 16'h1000;
    b_i = 16'h0234;
    cin_i = 1'b0;
    sb.push_back(17'h01234);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    a_i = 16'hFFFF;
    b_i = 16'hFFFF;
    cin_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("ignored_start_pulses", done_cnt - d0, 1);
    chk("ignored_start_sum", 32'(sum_o), 32'h1234);

    // Reset at RUN k=2 aborts without a done pulse
    d0 = done_cnt;
    start_i = 1'b1;
    a_i = 16'hFFFF;
    b_i = 16'hFFFF;
    cin_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_sum", 32'(sum_o), 32'd0);
    chk("abort_cout", 32'(cout_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_add_a", 32'(add_a_o), 32'd0);
    rst_i = 1'b0;
    run_op(16'h0102, 16'h0304, 1'b0, 17'h00406);
    chk("abort_pulses", done_cnt - d0, 1);

    // start_i held high: one result every 6 cycles
    start_i = 1'b1;
    a_i = 16'h8000;
    b_i = 16'h8000;
    cin_i = 1'b0;
    repeat (3) sb.push_back(17'h10000);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 13) start_i = 1'b0;
      if (done_o) pos.push_back(i);
    end
    chk("held_start_count", pos.size(), 3);
    if (pos.size() == 3) begin
      chk("held_start_t0", pos[0], 5);
      chk("held_start_t1", pos[1], 11);
      chk("held_start_t2", pos[2], 17);
    end

    // Random regression
    for (int n = 0; n < 1000; n++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 17'(rc));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_nibble_add_ctrl.md
SERIAL_NIBBLE_ADD_CTRL -- requirements
Module: serial_nibble_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 clk_i  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 start_i  input  1  request a new addition; sampled only in IDLE.
REQ-005 a_i  input  WIDTH  operand A; captured on an accepted start.
REQ-006 b_i  input  WIDTH  operand B; captured on an accepted start.
REQ-007 cin_i  input  1  initial carry-in; captured on an accepted start.
REQ-008 busy_o  output  1  high while an addition is in progress (RUN or DONE state).
REQ-009 done_o  output  1  one-cycle pulse when sum_o and cout_o become valid.
REQ-010 sum_o  output  WIDTH  result; held stable from done_o until the next accepted start.
REQ-011 cout_o  output  1  final carry-out; held with sum_o.
REQ-012 add_a_o  output  4  nibble of A driven to the external 4-bit adder.
REQ-013 add_b_o  output  4  nibble of B driven to the external 4-bit adder.
REQ-014 add_cin_o  output  1  carry driven to the external adder.
REQ-015 add_s_i  input  4  sum nibble returned by the external combinational adder.
REQ-016 add_cout_i  input  1  carry-out returned by the external adder.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-018 IDLE with start_i=1 SHALL latch a_i, b_i and cin_i, set nibble index k=0, set the carry register to cin_i, clear sum_o and cout_o, and enter RUN.
REQ-019 In RUN, add_a_o, add_b_o and add_cin_o SHALL equal nibble k of the latched A, nibble k of the latched B, and the carry register, all driven combinationally from registers.
REQ-020 At each RUN clock edge, the block SHALL write add_s_i into sum bits [4k+3:4k], load add_cout_i into the carry register, and increment k.
REQ-021 After the edge that processes k=WIDTH/4-1, the FSM SHALL enter DONE and load cout_o from add_cout_i.
REQ-022 DONE SHALL last one cycle with done_o=1, then the FSM SHALL return to IDLE.
REQ-023 Latency: start accepted at edge N gives done_o=1 in cycle N+WIDTH/4+1 (cycle 5 after acceptance for WIDTH=16).
REQ-024 start_i SHALL be ignored in RUN and DONE; it is not queued, and latched operands do not change.
REQ-025 start_i in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back throughput is one result per WIDTH/4+2 cycles).
REQ-026 In IDLE and DONE, add_a_o, add_b_o and add_cin_o SHALL be 0.
REQ-027 Arithmetic SHALL be unsigned and modulo 2^WIDTH, with the carry out of the top nibble reported only on cout_o.
REQ-028 Changes on a_i, b_i or cin_i after acceptance SHALL have no effect on the result.

Reset
REQ-029 With rst_i=1 at a clock edge, the block SHALL enter IDLE and clear k, the carry register, the operand registers, sum_o, cout_o, busy_o and done_o to 0.
REQ-030 Reset asserted during RUN or DONE SHALL abort the operation with no done_o pulse; reset SHALL take priority over start_i.
REQ-031 The first start SHALL be accepted at the first edge after rst_i deasserts.

Verification
REQ-032 WIDTH=16, A=0xFFFF, B=0x0001, cin=0 -> done_o in cycle 5, sum_o=0x0000, cout_o=1.
REQ-033 A=0x1234, B=0x4321, cin=1 -> sum_o=0x5556, cout_o=0; add_a_o sequence 4,3,2,1 over the four RUN cycles.
REQ-034 Pulse start_i during RUN with different operands -> ignored; result matches the first operands; exactly one done_o pulse.
REQ-035 rst_i asserted at RUN k=2 -> next cycle busy_o=0, sum_o=0, cout_o=0, and no done_o pulse.
REQ-036 start_i held high continuously, A=0x8000, B=0x8000 -> done_o repeats every 6 cycles with sum_o=0x0000, cout_o=1.
REQ-037 Random regression of 1000 operand triples -> {cout_o,sum_o} equals A+B+cin for every result.
